// File: rtl/sample_pkg.sv
// rtl/sample_pkg.sv - shared constants and state encoding for the sampler round sequencer
package sample_pkg;

    localparam int BIT_WID     = 8;
    localparam int POSSI_S     = 32;
    localparam int RESULT_SIZE = 5;
    localparam int LANES       = 32;
    localparam int CNT_W       = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        ISSUE = ST_ISSUE,
        OUT   = ST_OUT,
        FIN   = ST_FIN
    } state_t;

endpackage

// File: rtl/sample_distr_accum.sv
// rtl/sample_distr_accum.sv - builds the saturating cumulative distribution table from probability beats
module sample_distr_accum #(
    parameter int BIT_WID = 8,
    parameter int POSSI_S = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       accept,
    input  logic [BIT_WID-1:0]         data,
    output logic [BIT_WID*POSSI_S-1:0] accu_distr,
    output logic                       last
);
    import sample_pkg::*;

    localparam int IDX_W = $clog2(POSSI_S);

    logic [IDX_W-1:0]   beat_cnt;
    logic [BIT_WID-1:0] run_sum;
    logic [BIT_WID:0]   sum_wide;
    logic [BIT_WID-1:0] sum_sat;

    // One extra carry bit detects overflow so the table clamps instead of wrapping.
    assign sum_wide = {1'b0, run_sum} + {1'b0, data};
    assign sum_sat  = sum_wide[BIT_WID] ? {BIT_WID{1'b1}} : sum_wide[BIT_WID-1:0];
    assign last     = accept && (beat_cnt == IDX_W'(POSSI_S - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            run_sum  <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            run_sum  <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            run_sum  <= sum_sat;
        end
    end

    for (genvar i = 0; i < POSSI_S; i++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                accu_distr[BIT_WID*i +: BIT_WID] <= '0;
            end else if (clear) begin
                accu_distr[BIT_WID*i +: BIT_WID] <= '0;
            end else if (accept && (beat_cnt == IDX_W'(i))) begin
                accu_distr[BIT_WID*i +: BIT_WID] <= sum_sat;
            end
        end
    end

endmodule

// File: rtl/sample_round_ctrl.sv
// rtl/sample_round_ctrl.sv - loads the distribution, then runs sampling rounds and hands results downstream
module sample_round_ctrl #(
    parameter int BIT_WID     = 8,
    parameter int POSSI_S     = 32,
    parameter int RESULT_SIZE = 5,
    parameter int LANES       = 32,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             rounds,
    input  logic                         abort,
    input  logic                         dist_valid,
    output logic                         dist_ready,
    input  logic [BIT_WID-1:0]           dist_data,
    output logic [BIT_WID*POSSI_S-1:0]   accu_distr,
    output logic                         samp_enable,
    input  logic                         samp_ready,
    input  logic                         samp_done,
    input  logic [RESULT_SIZE*LANES-1:0] samp_result,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [RESULT_SIZE*LANES-1:0] res_data,
    output logic                         busy,
    output logic                         job_done,
    output logic [CNT_W-1:0]             round_cnt
);
    import sample_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] rounds_reg;
    logic             abort_pend;
    logic             pend_nxt;
    logic             accept;
    logic             last_beat;
    logic             clear_tbl;
    logic             take_job;
    logic             capture;
    logic             drop_valid;
    logic             fin_pulse;

    assign dist_ready  = (state == LOAD);
    assign samp_enable = (state == ISSUE) && samp_ready;
    assign busy        = (state != IDLE);
    assign accept      = dist_valid && dist_ready;

    sample_distr_accum #(
        .BIT_WID (BIT_WID),
        .POSSI_S (POSSI_S)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_tbl),
        .accept     (accept),
        .data       (dist_data),
        .accu_distr (accu_distr),
        .last       (last_beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pend_nxt   = abort_pend;
        clear_tbl  = 1'b0;
        take_job   = 1'b0;
        capture    = 1'b0;
        drop_valid = 1'b0;
        fin_pulse  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    take_job = 1'b1;
                    if (rounds != '0) begin
                        clear_tbl = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = FIN;
                end else if (last_beat) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Lanes only leave their finish state via samp_done, so an abort waits for it.
                if (abort) begin
                    pend_nxt = 1'b1;
                end
                if (samp_done) begin
                    pend_nxt = 1'b0;
                    if (abort || abort_pend) begin
                        state_nxt = FIN;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = OUT;
                    end
                end
            end
            OUT: begin
                if (abort) begin
                    drop_valid = 1'b1;
                    state_nxt  = FIN;
                end else if (res_ready) begin
                    drop_valid = 1'b1;
                    state_nxt  = (round_cnt == rounds_reg) ? FIN : ISSUE;
                end
            end
            FIN: begin
                fin_pulse = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rounds_reg <= '0;
            round_cnt  <= '0;
            abort_pend <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            job_done   <= 1'b0;
        end else begin
            job_done   <= fin_pulse;
            abort_pend <= pend_nxt;
            if (take_job) begin
                rounds_reg <= rounds;
                round_cnt  <= '0;
            end
            if (capture) begin
                res_data  <= samp_result;
                res_valid <= 1'b1;
                round_cnt <= round_cnt + 1'b1;
            end else if (drop_valid) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
